mem_ctrl: RTL and testbench

//  Byte-serial memory controller between the core and the 8-bit unified RAM/IO port.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIfRd = 2'd1,
        StLsRd = 2'd2,
        StLsWr = 2'd3
    } mc_state_e;

    // Byte-count codes carried on LSB_len
    localparam logic [2:0] LenB = 3'd1;
    localparam logic [2:0] LenH = 3'd2;
    localparam logic [2:0] LenW = 3'd4;

    // addr[17:16] value that maps an access into IO space
    localparam logic [1:0] IoSelDefault = 2'b11;

    function automatic logic is_io(input logic [1:0] addr_hi, input logic [1:0] sel);
        return addr_hi == sel;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: 32-bit instruction fetches and 1/2/4-byte
// loads/stores over an 8-bit RAM/IO port, one transaction at a time.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned AddrW = 32,
    parameter logic [1:0]  IoSel = IoSelDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong_stall,
    input  logic             IF_req,
    input  logic [AddrW-1:0] IF_addr,
    output logic             IF_flag,
    output logic [31:0]      IF_inst,
    input  logic             LSB_req,
    input  logic             LSB_wr,
    input  logic [AddrW-1:0] LSB_addr,
    input  logic [2:0]       LSB_len,
    input  logic [31:0]      LSB_wdata,
    output logic             LSB_flag,
    output logic [31:0]      LSB_rdata,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [AddrW-1:0] mem_a,
    output logic             mem_wr,
    input  logic             io_buffer_full
);

    mc_state_e        state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [2:0]       len_q, len_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      buf_q, buf_d;
    logic [AddrW-1:0] mem_a_q, mem_a_d;
    logic [7:0]       mem_dout_q, mem_dout_d;
    logic             mem_wr_q, mem_wr_d;
    logic             if_flag_q, if_flag_d;
    logic             lsb_flag_q, lsb_flag_d;
    logic [31:0]      if_inst_q, if_inst_d;
    logic [31:0]      lsb_rdata_q, lsb_rdata_d;

    logic [2:0]       cnt_nx;
    logic [1:0]       ridx;
    logic [31:0]      buf_ins;
    logic             io_hold;

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign IF_flag   = if_flag_q;
    assign IF_inst   = if_inst_q;
    assign LSB_flag  = lsb_flag_q;
    assign LSB_rdata = lsb_rdata_q;

    // Next-state and registered-output logic for the single transaction FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_flag_d   = 1'b0;
        lsb_flag_d  = 1'b0;
        if_inst_d   = if_inst_q;
        lsb_rdata_d = lsb_rdata_q;

        cnt_nx = cnt_q + 3'd1;
        // cnt counts addresses issued; the byte arriving now belongs to address cnt-1
        ridx    = cnt_q[1:0] - 2'd1;
        buf_ins = buf_q;
        buf_ins[{ridx, 3'b000} +: 8] = mem_din;
        io_hold = is_io(addr_q[17:16], IoSel) && io_buffer_full;

        unique case (state_q)
            StIdle: begin
                if (!jump_wrong_stall) begin
                    if (LSB_req) begin
                        addr_d  = LSB_addr;
                        len_d   = LSB_len;
                        wdata_d = LSB_wdata;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                        mem_a_d = LSB_addr;
                        if (LSB_wr) begin
                            state_d    = StLsWr;
                            mem_dout_d = LSB_wdata[7:0];
                            mem_wr_d   = !(is_io(LSB_addr[17:16], IoSel) && io_buffer_full);
                        end else begin
                            state_d = StLsRd;
                        end
                    end else if (IF_req) begin
                        addr_d  = IF_addr;
                        len_d   = LenW;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                        mem_a_d = IF_addr;
                        state_d = StIfRd;
                    end
                end
            end
            StIfRd, StLsRd: begin
                if (jump_wrong_stall) begin
                    // Flush beats a coincident flag
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                    mem_a_d = '0;
                end else if (cnt_q == len_q) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                    mem_a_d = '0;
                    if (state_q == StIfRd) begin
                        if_flag_d = 1'b1;
                        if_inst_d = buf_ins;
                    end else begin
                        lsb_flag_d  = 1'b1;
                        lsb_rdata_d = buf_ins;
                    end
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d = buf_ins;
                    end
                    cnt_d = cnt_nx;
                    if (cnt_nx < len_q) begin
                        mem_a_d = addr_q + AddrW'(cnt_nx);
                    end
                end
            end
            StLsWr: begin
                if (mem_wr_q) begin
                    // Byte cnt was written this cycle
                    if (cnt_nx == len_q) begin
                        state_d    = StIdle;
                        cnt_d      = 3'd0;
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        lsb_flag_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_nx;
                        mem_a_d    = addr_q + AddrW'(cnt_nx);
                        mem_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                        mem_wr_d   = !io_hold;
                    end
                end else begin
                    // Holding for the UART buffer; retry the same byte
                    mem_wr_d = !io_hold;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            len_q       <= 3'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_flag_q   <= 1'b0;
            lsb_flag_q  <= 1'b0;
            if_inst_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_flag_q   <= if_flag_d;
            lsb_flag_q  <= lsb_flag_d;
            if_inst_q   <= if_inst_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a byte RAM model and flag scoreboards.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_wrong_stall;
    logic        IF_req;
    logic [31:0] IF_addr;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic        LSB_req;
    logic        LSB_wr;
    logic [31:0] LSB_addr;
    logic [2:0]  LSB_len;
    logic [31:0] LSB_wdata;
    logic        LSB_flag;
    logic [31:0] LSB_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_checks = 0;
    int n_errors = 0;
    int io_wr_cnt = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] exp_if[$];
    logic [31:0] exp_lsb[$];
    bit          exp_lsb_store[$];

    mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .jump_wrong_stall (jump_wrong_stall),
        .IF_req           (IF_req),
        .IF_addr          (IF_addr),
        .IF_flag          (IF_flag),
        .IF_inst          (IF_inst),
        .LSB_req          (LSB_req),
        .LSB_wr           (LSB_wr),
        .LSB_addr         (LSB_addr),
        .LSB_len          (LSB_len),
        .LSB_wdata        (LSB_wdata),
        .LSB_flag         (LSB_flag),
        .LSB_rdata        (LSB_rdata),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full   (io_buffer_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RAM model: one-cycle read latency, writes and reads gated by rdy
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        end
    end

    // Scoreboard: pop an expectation for every flag pulse
    always @(negedge clk) begin
        if (!rst && mem_wr && mem_a == 32'h0003_0000) io_wr_cnt++;
        if (!rst && IF_flag) begin
            if (exp_if.size() == 0) check("if_spurious_flag", {31'd0, IF_flag}, 32'd0);
            else check("if_data", IF_inst, exp_if.pop_front());
        end
        if (!rst && LSB_flag) begin
            if (exp_lsb.size() == 0) begin
                check("lsb_spurious_flag", {31'd0, LSB_flag}, 32'd0);
            end else begin
                logic [31:0] d;
                bit          st;
                d  = exp_lsb.pop_front();
                st = exp_lsb_store.pop_front();
                if (!st) check("lsb_rdata", LSB_rdata, d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a flag, bounded; edges counts clock edges until it shows
    task automatic wait_flag(input bit is_lsb, output int edges);
        logic f;
        edges = 0;
        f = 1'b0;
        while (edges < 40 && !f) begin
            tick();
            edges++;
            f = is_lsb ? LSB_flag : IF_flag;
        end
        if (!f) check(is_lsb ? "lsb_flag_timeout" : "if_flag_timeout", {31'd0, f}, 32'd1);
    endtask

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ram[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
        int e;
        IF_addr = a;
        IF_req  = 1'b1;
        exp_if.push_back(exp);
        wait_flag(1'b0, e);
        IF_req = 1'b0;
        check("fetch_latency", 32'(e), 32'd6);
        tick();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] len, input logic [31:0] exp);
        int e;
        LSB_addr = a;
        LSB_len  = len;
        LSB_wr   = 1'b0;
        LSB_req  = 1'b1;
        exp_lsb.push_back(exp);
        exp_lsb_store.push_back(1'b0);
        wait_flag(1'b1, e);
        LSB_req = 1'b0;
        check("load_latency", 32'(e), 32'(len) + 32'd2);
        tick();
    endtask

    initial begin
        int e;
        logic [31:0] held_a;
        logic [7:0]  wb [4];

        rst = 1'b1; rdy = 1'b1; jump_wrong_stall = 1'b0;
        IF_req = 1'b0; IF_addr = 32'd0;
        LSB_req = 1'b0; LSB_wr = 1'b0; LSB_addr = 32'd0; LSB_len = 3'd0; LSB_wdata = 32'd0;
        io_buffer_full = 1'b0;
        put_word(32'h100, 32'h0000_0513);
        put_word(32'h200, 32'h1122_3344);
        ram[32'h2001] = 8'hFF;
        ram[32'h2002] = 8'h80;
        put_word(32'h300, 32'hDDCC_BBAA);
        put_word(32'h400, 32'hCAFE_F00D);
        put_word(32'h500, 32'h0403_0201);

        tick(); tick();
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_ctrl", {28'd0, mem_wr, IF_flag, LSB_flag, 1'b0}, 32'd0);
        check("rst_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_if_inst", IF_inst, 32'd0);
        check("rst_lsb_rdata", LSB_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // 1: fetch with address stepping and flag at the 5th edge after accept
        IF_addr = 32'h100;
        IF_req  = 1'b1;
        exp_if.push_back(32'h0000_0513);
        tick();
        check("t1_addr0", mem_a, 32'h100);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t1_addr", mem_a, 32'h100 + 32'(i));
        end
        wait_flag(1'b0, e);
        IF_req = 1'b0;
        check("t1_flag_edge", 32'(e) + 32'd3, 32'd5);
        tick();

        // 2: simultaneous requests, LSB first
        IF_addr = 32'h200; IF_req = 1'b1;
        exp_if.push_back(32'h1122_3344);
        LSB_addr = 32'h2001; LSB_len = 3'd2; LSB_wr = 1'b0; LSB_req = 1'b1;
        exp_lsb.push_back(32'h0000_80FF);
        exp_lsb_store.push_back(1'b0);
        tick();
        check("t2_lsb_first", mem_a, 32'h2001);
        wait_flag(1'b1, e);
        LSB_req = 1'b0;
        check("t2_lsb_edge", 32'(e), 32'd3);
        check("t2_if_not_yet", {31'd0, IF_flag}, 32'd0);
        wait_flag(1'b0, e);
        IF_req = 1'b0;
        tick();

        // 3: word store, then read it back
        wb[0] = 8'hEF; wb[1] = 8'hBE; wb[2] = 8'hAD; wb[3] = 8'hDE;
        LSB_addr = 32'h40; LSB_len = 3'd4; LSB_wdata = 32'hDEAD_BEEF; LSB_wr = 1'b1;
        LSB_req = 1'b1;
        exp_lsb.push_back(32'd0);
        exp_lsb_store.push_back(1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_wr", {31'd0, mem_wr}, 32'd1);
            check("t3_addr", mem_a, 32'h40 + 32'(i));
            check("t3_dout", {24'd0, mem_dout}, {24'd0, wb[i]});
        end
        tick();
        LSB_req = 1'b0;
        check("t3_flag", {31'd0, LSB_flag}, 32'd1);
        check("t3_wr_off", {31'd0, mem_wr}, 32'd0);
        tick();
        do_load(32'h40, 3'd4, 32'hDEAD_BEEF);
        do_load(32'h41, 3'd2, 32'h0000_ADBE);

        // 4: flush a fetch at cnt=2, then refetch
        IF_addr = 32'h300; IF_req = 1'b1;
        tick(); tick(); tick();
        check("t4_addr_pre", mem_a, 32'h302);
        jump_wrong_stall = 1'b1;
        IF_req = 1'b0;
        tick();
        check("t4_flush_a", mem_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_flag", {31'd0, IF_flag}, 32'd0);
        end
        jump_wrong_stall = 1'b0;
        do_fetch(32'h400, 32'hCAFE_F00D);

        // 5: IO store held while the UART buffer is full; flush is ignored
        io_wr_cnt = 0;
        io_buffer_full = 1'b1;
        LSB_addr = 32'h0003_0000; LSB_len = 3'd1; LSB_wdata = 32'h0000_0041; LSB_wr = 1'b1;
        LSB_req = 1'b1;
        exp_lsb.push_back(32'd0);
        exp_lsb_store.push_back(1'b1);
        tick();
        check("t5_hold0", {31'd0, mem_wr}, 32'd0);
        jump_wrong_stall = 1'b1;
        tick();
        check("t5_hold1", {31'd0, mem_wr}, 32'd0);
        tick();
        check("t5_hold2", {31'd0, mem_wr}, 32'd0);
        io_buffer_full = 1'b0;
        tick();
        check("t5_write", {31'd0, mem_wr}, 32'd1);
        check("t5_dout", {24'd0, mem_dout}, 32'h41);
        wait_flag(1'b1, e);
        LSB_req = 1'b0;
        jump_wrong_stall = 1'b0;
        check("t5_flag_edge", 32'(e), 32'd1);
        tick();
        check("t5_single_write", 32'(io_wr_cnt), 32'd1);
        do_load(32'h0003_0000, 3'd1, 32'h0000_0041);

        // 6: rdy low for two cycles in the middle of a word load
        LSB_addr = 32'h500; LSB_len = 3'd4; LSB_wr = 1'b0; LSB_req = 1'b1;
        exp_lsb.push_back(32'h0403_0201);
        exp_lsb_store.push_back(1'b0);
        tick(); tick(); tick();
        held_a = mem_a;
        check("t6_addr", held_a, 32'h502);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_frozen_a", mem_a, 32'h502);
            check("t6_frozen_flag", {31'd0, LSB_flag}, 32'd0);
        end
        rdy = 1'b1;
        wait_flag(1'b1, e);
        LSB_req = 1'b0;
        check("t6_remaining", 32'(e), 32'd3);
        tick(); tick();

        check("if_sb_empty", 32'(exp_if.size()), 32'd0);
        check("lsb_sb_empty", 32'(exp_lsb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
